// File: rtl/dmem_responder_if.sv
// dmem_responder_if -- request/response bundle between the MEM stage and the
// data-memory responder.
//   req    : request valid from the MEM stage
//   we     : 1 = store, 0 = load
//   addr   : byte address
//   wdata  : store data
//   ready  : responder idle, request may be accepted this cycle
//   ack    : one-cycle completion pulse
//   rdata  : load data, valid while ack = 1
//   err    : access fault, valid while ack = 1
interface dmem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        ack;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, addr, wdata,
      input  ready, ack, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata,
      output ready, ack, rdata, err
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder -- word-addressed data memory with a fixed access latency,
// serving one load/store at a time from the MEM stage.
//   CLK   : system clock, rising edge
//   Clrn  : asynchronous active-low reset (clears memory as well)
//   bus   : dmem_responder_if.slave (req/we/addr/wdata in, ready/ack/rdata/err out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready high; a req on the next edge is accepted and captured
// S_WAIT | latency countdown; commit (write or read) when cnt reaches 0
// S_RESP | ack high for one cycle with rdata/err
module dmem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic              CLK,
   input  logic              Clrn,
   dmem_responder_if.slave   bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            we_q;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;
   logic            ack_q;
   logic            err_q;
   logic [31:0]     rdata_q;
   logic [31:0]     mem_q [DEPTH];

   logic            fault_d;
   logic [AW-1:0]   idx_d;
   logic [31:0]     rdata_d;

   // Range check uses the full word address so high address bits that alias
   // onto a valid index are still rejected.
   assign fault_d = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
   assign idx_d   = addr_q[AW+1:2];
   assign rdata_d = (!fault_d && !we_q) ? mem_q[idx_d] : 32'd0;

   // ready is gated by Clrn so the MEM stage sees a stall for the whole reset.
   assign bus.ready = (state_q == S_IDLE) && Clrn;
   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;

   always_ff @(posedge CLK or negedge Clrn) begin
      if (!Clrn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req) begin
                  we_q    <= bus.we;
                  addr_q  <= bus.addr;
                  wdata_q <= bus.wdata;
                  cnt_q   <= CW'(LATENCY - 1);
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  // rdata_d reads the pre-write array value at this edge.
                  state_q <= S_RESP;
                  ack_q   <= 1'b1;
                  err_q   <= fault_d;
                  rdata_q <= rdata_d;
                  if (!fault_d && we_q) begin
                     mem_q[idx_d] <= wdata_q;
                  end
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
            end
            default: begin
               state_q <= S_IDLE;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- drives two responders (LATENCY 2 and 1) with the same
// stimulus; a reference model predicts acceptance, memory contents and the
// ack cycle of every access, and a scoreboard compares each ack.
module tb_dmem_responder;

   localparam int DEPTH = 64;
   localparam int L0    = 2;
   localparam int L1    = 1;

   logic        CLK  = 1'b0;
   logic        Clrn = 1'b0;
   logic        req_s   = 1'b0;
   logic        we_s    = 1'b0;
   logic [31:0] addr_s  = '0;
   logic [31:0] wdata_s = '0;

   always #5 CLK = ~CLK;

   dmem_responder_if b0 ();
   dmem_responder_if b1 ();

   assign b0.req = req_s;   assign b1.req = req_s;
   assign b0.we = we_s;     assign b1.we = we_s;
   assign b0.addr = addr_s; assign b1.addr = addr_s;
   assign b0.wdata = wdata_s; assign b1.wdata = wdata_s;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(L0)) u_dut0 (.CLK(CLK), .Clrn(Clrn), .bus(b0));
   dmem_responder #(.DEPTH(DEPTH), .LATENCY(L1)) u_dut1 (.CLK(CLK), .Clrn(Clrn), .bus(b1));

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] cyc;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] mem0 [DEPTH];
   logic [31:0] mem1 [DEPTH];
   int          busy0 = 0;
   int          busy1 = 0;
   logic [31:0] cyc = '0;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference behaviour of one acceptance, using the inputs at this edge.
   task automatic accept(input int inst);
      exp_t        e;
      logic        fault;
      logic [5:0]  idx;
      fault   = (addr_s[1:0] != 2'b00) || (addr_s[31:2] >= 30'(DEPTH));
      idx     = addr_s[7:2];
      e.err   = fault;
      e.rdata = '0;
      e.cyc   = cyc + 32'((inst == 0) ? L0 : L1);
      if (!fault) begin
         if (inst == 0) begin
            if (we_s) mem0[idx] = wdata_s; else e.rdata = mem0[idx];
         end else begin
            if (we_s) mem1[idx] = wdata_s; else e.rdata = mem1[idx];
         end
      end
      if (inst == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   // Model: tracks when each responder is idle and pushes expectations.
   initial begin
      for (int i = 0; i < DEPTH; i++) begin mem0[i] = '0; mem1[i] = '0; end
      forever begin
         @(posedge CLK);
         cyc = cyc + 1;
         if (!Clrn) begin
            q0.delete(); q1.delete();
            busy0 = 0; busy1 = 0;
            for (int i = 0; i < DEPTH; i++) begin mem0[i] = '0; mem1[i] = '0; end
         end else begin
            if (busy0 == 0 && req_s) begin accept(0); busy0 = L0 + 1; end
            else if (busy0 > 0) busy0--;
            if (busy1 == 0 && req_s) begin accept(1); busy1 = L1 + 1; end
            else if (busy1 > 0) busy1--;
         end
      end
   end

   // Monitors sample mid-cycle on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         check("ready0", 32'(b0.ready), 32'(busy0 == 0 && Clrn));
         if (b0.ack) begin
            if (q0.size() == 0) check("spurious_ack0", 32'(b0.ack), 32'd0);
            else begin
               e = q0.pop_front();
               check("rdata0", b0.rdata, e.rdata);
               check("err0", 32'(b0.err), 32'(e.err));
               check("ack_cycle0", cyc, e.cyc);
            end
         end else begin
            check("rdata_idle0", b0.rdata, 32'd0);
            check("err_idle0", 32'(b0.err), 32'd0);
            if (Clrn && q0.size() > 0 && q0[0].cyc <= cyc) begin
               check("missing_ack0", 32'(b0.ack), 32'd1);
               void'(q0.pop_front());
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         check("ready1", 32'(b1.ready), 32'(busy1 == 0 && Clrn));
         if (b1.ack) begin
            if (q1.size() == 0) check("spurious_ack1", 32'(b1.ack), 32'd0);
            else begin
               e = q1.pop_front();
               check("rdata1", b1.rdata, e.rdata);
               check("err1", 32'(b1.err), 32'(e.err));
               check("ack_cycle1", cyc, e.cyc);
            end
         end else begin
            check("rdata_idle1", b1.rdata, 32'd0);
            check("err_idle1", 32'(b1.err), 32'd0);
            if (Clrn && q1.size() > 0 && q1[0].cyc <= cyc) begin
               check("missing_ack1", 32'(b1.ack), 32'd1);
               void'(q1.pop_front());
            end
         end
      end
   end

   // Called on a falling edge with both responders idle; returns on a
   // falling edge with both idle again.
   task automatic do_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      req_s = 1'b1; we_s = we; addr_s = addr; wdata_s = wdata;
      @(posedge CLK);
      #1 req_s = 1'b0;
      addr_s  = 32'hFFFF_FFFF;
      wdata_s = 32'h0BAD_0BAD;
      repeat (L0 + 2) @(negedge CLK);
   endtask

   initial begin
      #3;
      check("rst_ready0", 32'(b0.ready), 32'd0);
      check("rst_ack0", 32'(b0.ack), 32'd0);
      check("rst_rdata0", b0.rdata, 32'd0);
      check("rst_err1", 32'(b1.err), 32'd0);
      repeat (3) @(posedge CLK);
      #2 Clrn = 1'b1;
      @(negedge CLK);

      do_acc(1'b1, 32'h10, 32'hDEAD_BEEF);
      do_acc(1'b0, 32'h10, 32'h0);
      do_acc(1'b1, 32'h12, 32'h1);          // misaligned store
      do_acc(1'b0, 32'h10, 32'h0);
      do_acc(1'b0, 32'h100, 32'h0);         // index == DEPTH
      do_acc(1'b0, 32'hFC, 32'h0);          // last word, still reset value
      do_acc(1'b1, 32'hFC, 32'h1234_5678);
      do_acc(1'b0, 32'hFC, 32'h0);
      do_acc(1'b1, 32'h8000_0010, 32'h5555_AAAA); // high bits alias index 4
      do_acc(1'b0, 32'h10, 32'h0);
      do_acc(1'b0, 32'h13, 32'h0);

      // req held high; inputs change every cycle.
      for (int k = 0; k < 40; k++) begin
         int w;
         w = $urandom_range(0, 7);
         if ($urandom_range(0, 5) == 0) w = w + 60;
         req_s   = 1'b1;
         we_s    = 1'($urandom_range(0, 1));
         addr_s  = 32'(w << 2) | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
         wdata_s = $urandom;
         @(negedge CLK);
      end
      req_s = 1'b0;
      repeat (L0 + 2) @(negedge CLK);

      // Reset while the store to 0x20 is in flight.
      do_acc(1'b1, 32'h20, 32'h77);
      req_s = 1'b1; we_s = 1'b1; addr_s = 32'h20; wdata_s = 32'h5;
      @(posedge CLK);
      #1 req_s = 1'b0;
      @(posedge CLK);
      #2 Clrn = 1'b0;
      #1 check("ready_in_rst0", 32'(b0.ready), 32'd0);
      check("ack_in_rst1", 32'(b1.ack), 32'd0);
      repeat (2) @(posedge CLK);
      #2 Clrn = 1'b1;
      @(negedge CLK);
      check("ready_after_rst0", 32'(b0.ready), 32'd1);
      do_acc(1'b0, 32'h20, 32'h0);

      repeat (4) @(negedge CLK);
      check("sb_empty0", 32'(q0.size()), 32'd0);
      check("sb_empty1", 32'(q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
